// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
// release_grant carries the grantee's "done" strobe.
interface rr_grant_arbiter_if #(
  parameter int IDX_WIDTH = 2
);
  localparam int NUM_REQ = 1 << IDX_WIDTH;

  logic [NUM_REQ-1:0]   req;
  logic                 release_grant;
  logic                 grant_valid;
  logic [IDX_WIDTH-1:0] grant_idx;
  logic [NUM_REQ-1:0]   grant_onehot;
  logic                 hold_timeout;

  // Requester side: raises requests and signals completion of its grant
  modport master (
    output req,
    output release_grant,
    input  grant_valid,
    input  grant_idx,
    input  grant_onehot,
    input  hold_timeout
  );

  // Arbiter side
  modport slave (
    input  req,
    input  release_grant,
    output grant_valid,
    output grant_idx,
    output grant_onehot,
    output hold_timeout
  );
endinterface

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter: grants one of NUM_REQ requesters, holds the grant until
// release or MAX_HOLD expiry, then re-arbitrates with the old grantee lowest.
// All outputs are registered; there is no input-to-output combinational path.
module rr_grant_arbiter #(
  parameter int IDX_WIDTH  = 2,
  parameter int MAX_HOLD   = 16,
  parameter int HOLD_WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst,
  rr_grant_arbiter_if.slave  bus
);

  localparam int unsigned NUM_REQ = 1 << IDX_WIDTH;
  localparam logic [HOLD_WIDTH-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? '0 : HOLD_WIDTH'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t                state, state_nxt;
  logic [IDX_WIDTH-1:0]  last_q, last_nxt;
  logic [IDX_WIDTH-1:0]  idx_q, idx_nxt;
  logic                  valid_q, valid_nxt;
  logic [NUM_REQ-1:0]    onehot_q, onehot_nxt;
  logic                  timeout_q, timeout_nxt;
  logic [HOLD_WIDTH-1:0] cnt_q, cnt_nxt;

  logic                  pick_found;
  logic [IDX_WIDTH-1:0]  pick_idx;
  logic                  expire;
  logic                  grant_end;

  // Timeout only fires when the grantee did not release in the same cycle
  assign expire    = (MAX_HOLD != 0) && (state == GRANT) &&
                     (cnt_q == HOLD_LAST) && !bus.release_grant;
  assign grant_end = (state == GRANT) && (bus.release_grant || expire);

  // Rotating priority search starting just above the last grantee; the last
  // grantee is visited last, so it only wins when it is the sole requester
  always_comb begin
    logic [IDX_WIDTH-1:0] cand;
    pick_found = 1'b0;
    pick_idx   = last_q;
    cand       = last_q;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = last_q + IDX_WIDTH'(i);
      if (!pick_found && bus.req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_q    <= '1;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      onehot_q  <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state     <= state_nxt;
      last_q    <= last_nxt;
      idx_q     <= idx_nxt;
      valid_q   <= valid_nxt;
      onehot_q  <= onehot_nxt;
      timeout_q <= timeout_nxt;
      cnt_q     <= cnt_nxt;
    end
  end

  // Next-state: grant when anyone requests, fall back to IDLE when a grant
  // ends with nobody left requesting
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pick_found) state_nxt = GRANT;
      GRANT:   if (grant_end && !pick_found) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next output values: a grant ending re-arbitrates in the same edge so
  // back-to-back grants have no idle bubble
  always_comb begin
    last_nxt    = last_q;
    idx_nxt     = idx_q;
    valid_nxt   = valid_q;
    timeout_nxt = 1'b0;
    cnt_nxt     = cnt_q;
    unique case (state)
      IDLE: begin
        valid_nxt = 1'b0;
        if (pick_found) begin
          valid_nxt = 1'b1;
          idx_nxt   = pick_idx;
          last_nxt  = pick_idx;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (grant_end) begin
          timeout_nxt = expire;
          cnt_nxt     = '0;
          if (pick_found) begin
            valid_nxt = 1'b1;
            idx_nxt   = pick_idx;
            last_nxt  = pick_idx;
          end else begin
            valid_nxt = 1'b0;
          end
        end else if (cnt_q != HOLD_LAST) begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      default: valid_nxt = 1'b0;
    endcase
    onehot_nxt = '0;
    if (valid_nxt) onehot_nxt[idx_nxt] = 1'b1;
  end

  assign bus.grant_valid  = valid_q;
  assign bus.grant_idx    = idx_q;
  assign bus.grant_onehot = onehot_q;
  assign bus.hold_timeout = timeout_q;

`ifndef SYNTHESIS
  onehot_at_most_one: assert property (@(posedge clk) disable iff (rst)
    $onehot0(onehot_q));
  onehot_tracks_idx: assert property (@(posedge clk) disable iff (rst)
    onehot_q == (valid_q ? (NUM_REQ'(1) << idx_q) : '0));
`endif

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Scoreboard bench for rr_grant_arbiter: stimulus pushes the expected
// post-edge outputs, a monitor pops and compares one entry per clock.
module tb_rr_grant_arbiter;

  localparam int IDX_WIDTH = 2;
  localparam int NUM_REQ   = 4;
  localparam int MAX_HOLD  = 16;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
    logic [3:0] onehot;
    logic       to;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rr_grant_arbiter_if #(.IDX_WIDTH(IDX_WIDTH)) bus ();

  rr_grant_arbiter #(
    .IDX_WIDTH (IDX_WIDTH),
    .MAX_HOLD  (MAX_HOLD),
    .HOLD_WIDTH(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t  sb[$];
  string tags[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  // reference model state for the random phase
  int m_valid, m_idx, m_last, m_cnt;

  task automatic chk(input string tag, input string what,
                     input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %b expected %b at %0t", tag, what, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the edge
  task automatic cyc(input logic [3:0] r, input logic rl, input logic rs,
                     input logic ev, input logic [1:0] ei, input logic et,
                     input string tag);
    exp_t e;
    @(negedge clk);
    bus.req           = r;
    bus.release_grant = rl;
    rst               = rs;
    e.valid  = ev;
    e.idx    = ei;
    e.onehot = ev ? (4'b0001 << ei) : 4'b0000;
    e.to     = et;
    sb.push_back(e);
    tags.push_back(tag);
  endtask

  // Monitor
  initial begin
    exp_t  e;
    string t;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        t = tags.pop_front();
        chk(t, "grant_valid",  {3'b000, bus.grant_valid},  {3'b000, e.valid});
        chk(t, "grant_idx",    {2'b00, bus.grant_idx},     {2'b00, e.idx});
        chk(t, "grant_onehot", bus.grant_onehot,           e.onehot);
        chk(t, "hold_timeout", {3'b000, bus.hold_timeout}, {3'b000, e.to});
      end
    end
  end

  // Stimulus
  initial begin
    logic [3:0] r;
    logic       rl;
    logic       to;
    bit         found;
    int         w;

    rst = 1'b1;
    bus.req = '0;
    bus.release_grant = 1'b0;

    repeat (2) cyc(4'b0000, 0, 1, 0, 2'd0, 0, "reset");

    // idle with no requests; release ignored while idle
    repeat (10) cyc(4'b0000, 0, 0, 0, 2'd0, 0, "idle");
    cyc(4'b0000, 1, 0, 0, 2'd0, 0, "idle_release");

    // all request, release every second grant cycle: 0,1,2,3,0 back to back
    for (int k = 0; k < 10; k++)
      cyc(4'b1111, (k >= 2 && k % 2 == 0), 0, 1, 2'((k / 2) % 4), 0, "rotate");
    cyc(4'b0000, 1, 0, 0, 2'd0, 0, "rotate_end");

    // sole requester re-granted after its own release
    cyc(4'b0100, 0, 0, 1, 2'd2, 0, "sole");
    cyc(4'b0100, 0, 0, 1, 2'd2, 0, "sole");
    cyc(4'b0100, 0, 0, 1, 2'd2, 0, "sole");
    cyc(4'b0100, 1, 0, 1, 2'd2, 0, "sole_regrant");
    cyc(4'b0100, 0, 0, 1, 2'd2, 0, "sole");
    cyc(4'b0000, 1, 0, 0, 2'd2, 0, "sole_drop");
    cyc(4'b0000, 0, 0, 0, 2'd2, 0, "idle_keep_idx");
    cyc(4'b0000, 1, 0, 0, 2'd2, 0, "idle_keep_idx");

    // hold timeout after 16 cycles, then release coincident with expiry
    cyc(4'b0011, 0, 0, 1, 2'd0, 0, "hold0");
    for (int k = 1; k < 16; k++) cyc(4'b0011, 0, 0, 1, 2'd0, 0, "hold0");
    cyc(4'b0011, 0, 0, 1, 2'd1, 1, "timeout");
    for (int k = 17; k < 32; k++) cyc(4'b0011, 0, 0, 1, 2'd1, 0, "hold1");
    cyc(4'b0011, 1, 0, 1, 2'd0, 0, "release_at_expiry");
    cyc(4'b0000, 1, 0, 0, 2'd0, 0, "hold_end");

    // reset in the middle of a grant restores requester 0 priority
    cyc(4'b1001, 0, 0, 1, 2'd3, 0, "pre_reset");
    cyc(4'b1001, 0, 1, 0, 2'd0, 0, "mid_reset");
    cyc(4'b1001, 0, 0, 1, 2'd0, 0, "post_reset");
    cyc(4'b1001, 1, 0, 1, 2'd3, 0, "post_reset");
    cyc(4'b0000, 1, 0, 0, 2'd3, 0, "post_reset_idle");

    // random traffic against a behavioural reference model
    cyc(4'b0000, 0, 1, 0, 2'd0, 0, "rnd_reset");
    m_valid = 0; m_idx = 0; m_last = NUM_REQ - 1; m_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      r  = 4'($urandom_range(0, 15));
      rl = ($urandom_range(0, 3) == 0);
      to = (m_valid != 0) && (m_cnt == MAX_HOLD - 1) && !rl;
      if (m_valid == 0 || rl || to) begin
        found = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
          w = (m_last + i) % NUM_REQ;
          if (!found && r[w]) begin
            found = 1;
            m_idx = w;
          end
        end
        m_cnt = 0;
        if (found) begin
          m_valid = 1;
          m_last  = m_idx;
        end else begin
          m_valid = 0;
        end
      end else begin
        m_cnt++;
      end
      cyc(r, rl, 0, (m_valid != 0), 2'(m_idx), (m_valid != 0 || found) ? to : 1'b0, "random");
    end

    // let the monitor drain the scoreboard, bounded
    for (int k = 0; k < 5 && sb.size() > 0; k++) @(posedge clk);
    #2;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
